lab2_proc_imul_arbiter: RTL

LAB2_PROC_IMUL_ARBITER -- requirements
Module: lab2_proc_ImulArbiter

---
 rtl/lab2_proc_imul_arbiter_pkg.sv | 14 +
 rtl/lab2_proc_imul_arbiter_rrpick.sv | 28 ++
 rtl/lab2_proc_imul_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lab2_proc_imul_arbiter_pkg.sv
// Shared types and widths for the iterative-multiplier arbiter.
package lab2_proc_ImulArbPkg;

    // Operand message {op1, op2} and product message widths.
    localparam int unsigned REQ_MSG_W  = 64;
    localparam int unsigned RESP_MSG_W = 32;

    // IDLE: nothing outstanding. BUSY: one transaction owned by a latched core.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/lab2_proc_imul_arbiter_rrpick.sv
// Combinational round-robin search: first set request bit at or above ptr,
// wrapping to index 0.
module lab2_proc_RoundRobinPick #(
    parameter int p_num_cores = 4,
    parameter int PW          = $clog2(p_num_cores)
) (
    input  logic [p_num_cores-1:0] i_req,
    input  logic [PW-1:0]          i_ptr,
    output logic [PW-1:0]          o_winner,
    output logic                   o_any_valid
);

    // Walk the candidates in priority order starting at ptr; keep the first hit.
    always_comb begin
        int w_idx;
        w_idx       = 0;
        o_winner    = '0;
        o_any_valid = 1'b0;
        for (int k = 0; k < p_num_cores; k++) begin
            w_idx = (int'(i_ptr) + k) % p_num_cores;
            if (!o_any_valid && i_req[w_idx]) begin
                o_any_valid = 1'b1;
                o_winner    = w_idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/lab2_proc_imul_arbiter.sv
// Arbiter sharing one iterative multiplier between p_num_cores requesters.
// Optional feature: define IMUL_ARB_STATS_EN to add the busy_cycles counter
// output (cycles spent in BUSY, wraps at 2^32).
//
// Handshakes: every stream transfers a message on a clock edge where its
// valid and ready are both high; valid does not depend on ready, while
// ready may depend on valid (req_rdy follows mul_req_rdy, mul_resp_rdy
// follows the owning core's resp_rdy).
module lab2_proc_imul_arbiter
    import lab2_proc_ImulArbPkg::*;
#(
    parameter int p_num_cores = 4,
    parameter int PW          = $clog2(p_num_cores)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [p_num_cores-1:0]           req_val,
    output logic [p_num_cores-1:0]           req_rdy,
    input  logic [REQ_MSG_W*p_num_cores-1:0] req_msg,
    output logic [p_num_cores-1:0]           resp_val,
    input  logic [p_num_cores-1:0]           resp_rdy,
    output logic [RESP_MSG_W-1:0]            resp_msg,
    output logic                             mul_req_val,
    input  logic                             mul_req_rdy,
    output logic [REQ_MSG_W-1:0]             mul_req_msg,
    input  logic                             mul_resp_val,
    output logic                             mul_resp_rdy,
    input  logic [RESP_MSG_W-1:0]            mul_resp_msg,
`ifdef IMUL_ARB_STATS_EN
    output logic [31:0]                      busy_cycles,
`endif
    output logic                             o_dbg_state,
    output logic [PW-1:0]                    o_dbg_rr_ptr
);

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] w_winner;
    logic          w_any_valid;
    logic          w_req_fire;
    logic          w_resp_fire;

    lab2_proc_RoundRobinPick #(
        .p_num_cores (p_num_cores),
        .PW          (PW)
    ) u_pick (
        .i_req       (req_val),
        .i_ptr       (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    // Transfer events on the multiplier side, qualified by the FSM state.
    assign w_req_fire  = (r_state == IDLE) && w_any_valid && mul_req_rdy;
    assign w_resp_fire = (r_state == BUSY) && mul_resp_val && resp_rdy[r_owner];

    // The product is broadcast; only the owner's resp_val qualifies it.
    assign resp_msg     = mul_resp_msg;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_req_fire) begin
                r_owner <= w_winner;
            end
            if (w_resp_fire) begin
                r_rr_ptr <= (r_owner == PW'(p_num_cores - 1)) ? '0 : r_owner + PW'(1);
            end
        end
    end

    // Next state and stream steering; everything is forced quiet under reset.
    always_comb begin
        w_state_next = r_state;
        req_rdy      = '0;
        resp_val     = '0;
        mul_req_val  = 1'b0;
        mul_req_msg  = '0;
        mul_resp_rdy = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    mul_req_val       = 1'b1;
                    mul_req_msg       = req_msg[REQ_MSG_W*int'(w_winner) +: REQ_MSG_W];
                    req_rdy[w_winner] = mul_req_rdy;
                    if (mul_req_rdy) begin
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                resp_val[r_owner] = mul_resp_val;
                mul_resp_rdy      = resp_rdy[r_owner];
                if (mul_resp_val && resp_rdy[r_owner]) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (reset) begin
            req_rdy      = '0;
            resp_val     = '0;
            mul_req_val  = 1'b0;
            mul_req_msg  = '0;
            mul_resp_rdy = 1'b0;
        end
    end

`ifdef IMUL_ARB_STATS_EN
    logic [31:0] r_busy_cycles;

    // Count every cycle spent owning the multiplier; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_cycles <= '0;
        end else if (r_state == BUSY) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign busy_cycles = r_busy_cycles;
`endif

endmodule
